// File: rtl/mcb_port_responder.sv
// Behavioural MCB user-port responder: command/write/read FIFOs in front of a
// word-addressed backing array, driven by a one-beat-per-cycle IDLE/WRITE/READ engine.
module mcb_port_responder #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned DATA_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pX_cmd_en,
  input  logic [2:0]  pX_cmd_instr,
  input  logic [5:0]  pX_cmd_bl,
  input  logic [29:0] pX_cmd_addr,
  output logic        pX_cmd_empty,
  output logic        pX_cmd_full,
  input  logic        pX_wr_en,
  input  logic [3:0]  pX_wr_mask,
  input  logic [31:0] pX_wr_data,
  output logic        pX_wr_full,
  output logic        pX_wr_empty,
  output logic [6:0]  pX_wr_count,
  output logic        pX_wr_underrun,
  output logic        pX_wr_error,
  input  logic        pX_rd_en,
  output logic [31:0] pX_rd_data,
  output logic        pX_rd_full,
  output logic        pX_rd_empty,
  output logic [6:0]  pX_rd_count,
  output logic        pX_rd_overflow,
  output logic        pX_rd_error
);
  localparam int unsigned MEM_WORDS = 1 << ADDR_BITS;
  localparam int unsigned CPW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CCW = $clog2(CMD_DEPTH + 1);
  localparam int unsigned DPW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned CEW = 3 + 6 + ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state;

  logic [31:0]          mem     [MEM_WORDS];
  logic [CEW-1:0]       cmd_mem [CMD_DEPTH];
  logic [35:0]          wr_mem  [DATA_DEPTH];
  logic [31:0]          rd_mem  [DATA_DEPTH];
  logic [CPW-1:0]       cmd_wp, cmd_rp;
  logic [CCW-1:0]       cmd_cnt;
  logic [DPW-1:0]       wr_wp, wr_rp, rd_wp, rd_rp;
  logic [6:0]           wr_cnt, rd_cnt;
  logic [ADDR_BITS-1:0] addr;
  logic [6:0]           beats;
  logic [CEW-1:0]       cmd_head;
  logic [35:0]          wr_head;
  logic [31:0]          wr_merged;
  logic                 cmd_push, cmd_pop, wr_push, wr_pop, rd_push, rd_pop;
  logic                 addr_unused;

  assign addr_unused = ^{pX_cmd_addr[1:0], pX_cmd_addr[29:ADDR_BITS+2]};

  assign pX_cmd_empty   = (cmd_cnt == '0);
  assign pX_cmd_full    = (cmd_cnt == CCW'(CMD_DEPTH));
  assign pX_wr_empty    = (wr_cnt == '0);
  assign pX_wr_full     = (wr_cnt == 7'(DATA_DEPTH));
  assign pX_wr_count    = wr_cnt;
  assign pX_rd_empty    = (rd_cnt == '0);
  assign pX_rd_full     = (rd_cnt == 7'(DATA_DEPTH));
  assign pX_rd_count    = rd_cnt;
  assign pX_rd_overflow = 1'b0;
  assign pX_rd_error    = 1'b0;

  assign cmd_head   = cmd_mem[cmd_rp];
  assign wr_head    = wr_mem[wr_rp];
  assign pX_rd_data = pX_rd_empty ? '0 : rd_mem[rd_rp];

  assign cmd_push = pX_cmd_en && !pX_cmd_full;
  assign cmd_pop  = (state == IDLE) && !pX_cmd_empty;
  assign wr_push  = pX_wr_en && !pX_wr_full;
  assign wr_pop   = (state == WRITE) && !pX_wr_empty;
  assign rd_push  = (state == READ) && !pX_rd_full;
  assign rd_pop   = pX_rd_en && !pX_rd_empty;

  // A set mask bit keeps the stored byte.
  always_comb begin
    wr_merged = mem[addr];
    for (int unsigned i = 0; i < 4; i++)
      if (!wr_head[32+i]) wr_merged[8*i +: 8] = wr_head[8*i +: 8];
  end

  // Storage arrays carry no reset; the backing array must survive reset.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp] <= {pX_cmd_instr, pX_cmd_bl, pX_cmd_addr[ADDR_BITS+1:2]};
    if (wr_push)  wr_mem[wr_wp]   <= {pX_wr_mask, pX_wr_data};
    if (rd_push)  rd_mem[rd_wp]   <= mem[addr];
    if (wr_pop)   mem[addr]       <= wr_merged;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
      wr_wp   <= '0;
      wr_rp   <= '0;
      wr_cnt  <= '0;
      rd_wp   <= '0;
      rd_rp   <= '0;
      rd_cnt  <= '0;
    end else begin
      if (cmd_push) cmd_wp <= (cmd_wp == CPW'(CMD_DEPTH - 1)) ? '0 : cmd_wp + CPW'(1);
      if (cmd_pop)  cmd_rp <= (cmd_rp == CPW'(CMD_DEPTH - 1)) ? '0 : cmd_rp + CPW'(1);
      if (cmd_push != cmd_pop) cmd_cnt <= cmd_push ? cmd_cnt + CCW'(1) : cmd_cnt - CCW'(1);
      if (wr_push) wr_wp <= (wr_wp == DPW'(DATA_DEPTH - 1)) ? '0 : wr_wp + DPW'(1);
      if (wr_pop)  wr_rp <= (wr_rp == DPW'(DATA_DEPTH - 1)) ? '0 : wr_rp + DPW'(1);
      if (wr_push != wr_pop) wr_cnt <= wr_push ? wr_cnt + 7'd1 : wr_cnt - 7'd1;
      if (rd_push) rd_wp <= (rd_wp == DPW'(DATA_DEPTH - 1)) ? '0 : rd_wp + DPW'(1);
      if (rd_pop)  rd_rp <= (rd_rp == DPW'(DATA_DEPTH - 1)) ? '0 : rd_rp + DPW'(1);
      if (rd_push != rd_pop) rd_cnt <= rd_push ? rd_cnt + 7'd1 : rd_cnt - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      beats          <= '0;
      pX_wr_underrun <= 1'b0;
      pX_wr_error    <= 1'b0;
    end else begin
      pX_wr_underrun <= 1'b0;
      if (pX_wr_en && pX_wr_full) pX_wr_error <= 1'b1;
      case (state)
        IDLE: begin
          if (cmd_pop) begin
            addr  <= cmd_head[ADDR_BITS-1:0];
            beats <= {1'b0, cmd_head[ADDR_BITS +: 6]} + 7'd1;
            case (cmd_head[CEW-1 -: 3])
              3'b000, 3'b010: state <= WRITE;
              3'b001, 3'b011: state <= READ;
              default:        state <= IDLE;
            endcase
          end
        end
        WRITE: begin
          // A starved beat still consumes its address slot.
          if (pX_wr_empty) begin
            pX_wr_underrun <= 1'b1;
            pX_wr_error    <= 1'b1;
          end
          addr  <= addr + ADDR_BITS'(1);
          beats <= beats - 7'd1;
          if (beats == 7'd1) state <= IDLE;
        end
        READ: begin
          if (!pX_rd_full) begin
            addr  <= addr + ADDR_BITS'(1);
            beats <= beats - 7'd1;
            if (beats == 7'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcb_port_responder.sv
// Randomised scoreboard bench for mcb_port_responder: a word-array model predicts
// read data at command issue; an independent monitor pops and compares read beats.
module tb_mcb_port_responder;
  localparam int unsigned MW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        pX_cmd_en;
  logic [2:0]  pX_cmd_instr;
  logic [5:0]  pX_cmd_bl;
  logic [29:0] pX_cmd_addr;
  logic        pX_cmd_empty, pX_cmd_full;
  logic        pX_wr_en;
  logic [3:0]  pX_wr_mask;
  logic [31:0] pX_wr_data;
  logic        pX_wr_full, pX_wr_empty;
  logic [6:0]  pX_wr_count;
  logic        pX_wr_underrun, pX_wr_error;
  logic        pX_rd_en;
  logic [31:0] pX_rd_data;
  logic        pX_rd_full, pX_rd_empty;
  logic [6:0]  pX_rd_count;
  logic        pX_rd_overflow, pX_rd_error;

  mcb_port_responder #(.ADDR_BITS(10), .CMD_DEPTH(4), .DATA_DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .pX_cmd_en(pX_cmd_en), .pX_cmd_instr(pX_cmd_instr), .pX_cmd_bl(pX_cmd_bl),
    .pX_cmd_addr(pX_cmd_addr), .pX_cmd_empty(pX_cmd_empty), .pX_cmd_full(pX_cmd_full),
    .pX_wr_en(pX_wr_en), .pX_wr_mask(pX_wr_mask), .pX_wr_data(pX_wr_data),
    .pX_wr_full(pX_wr_full), .pX_wr_empty(pX_wr_empty), .pX_wr_count(pX_wr_count),
    .pX_wr_underrun(pX_wr_underrun), .pX_wr_error(pX_wr_error),
    .pX_rd_en(pX_rd_en), .pX_rd_data(pX_rd_data), .pX_rd_full(pX_rd_full),
    .pX_rd_empty(pX_rd_empty), .pX_rd_count(pX_rd_count),
    .pX_rd_overflow(pX_rd_overflow), .pX_rd_error(pX_rd_error)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned und_cnt  = 0;
  bit          rd_allow = 1'b0;
  logic [31:0] mm  [MW];
  logic [35:0] wdq [$];
  logic [31:0] sb  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: word address is byte address / 4 modulo the array size; masked bytes kept.
  function automatic void model_cmd(input logic [2:0] instr, input logic [5:0] bl,
                                    input logic [29:0] baddr);
    int unsigned wa, a;
    logic [35:0] e;
    wa = (32'(baddr) / 4) % MW;
    for (int unsigned i = 0; i <= 32'(bl); i++) begin
      a = (wa + i) % MW;
      if (instr == 3'd0 || instr == 3'd2) begin
        if (wdq.size() > 0) begin
          e = wdq.pop_front();
          for (int b = 0; b < 4; b++)
            if (!e[32+b]) mm[a][8*b +: 8] = e[8*b +: 8];
        end
      end else if (instr == 3'd1 || instr == 3'd3) begin
        sb.push_back(mm[a]);
      end
    end
  endfunction

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    int unsigned t;
    t = 0;
    while (pX_wr_full && t < 3000) begin @(negedge clk); t++; end
    if (pX_wr_full) begin wait_expired("wr_push_wait"); return; end
    pX_wr_en = 1'b1; pX_wr_data = d; pX_wr_mask = m;
    @(negedge clk);
    pX_wr_en = 1'b0;
    wdq.push_back({m, d});
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] a);
    int unsigned t;
    t = 0;
    while (pX_cmd_full && t < 3000) begin @(negedge clk); t++; end
    if (pX_cmd_full) begin wait_expired("cmd_push_wait"); return; end
    pX_cmd_en = 1'b1; pX_cmd_instr = instr; pX_cmd_bl = bl; pX_cmd_addr = a;
    @(negedge clk);
    pX_cmd_en = 1'b0;
    model_cmd(instr, bl, a);
  endtask

  task automatic wait_idle();
    int unsigned t;
    rd_allow = 1'b1;
    t = 0;
    while ((sb.size() != 0 || !pX_cmd_empty || !pX_wr_empty) && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) wait_expired("drain");
    repeat (4) @(negedge clk);
    check("rd_empty_after_drain", 32'(pX_rd_empty), 32'd1);
  endtask

  task automatic check_reset(input string p);
    check({p, "_cmd_empty"},   32'(pX_cmd_empty),   32'd1);
    check({p, "_cmd_full"},    32'(pX_cmd_full),    32'd0);
    check({p, "_wr_empty"},    32'(pX_wr_empty),    32'd1);
    check({p, "_wr_full"},     32'(pX_wr_full),     32'd0);
    check({p, "_wr_count"},    32'(pX_wr_count),    32'd0);
    check({p, "_rd_empty"},    32'(pX_rd_empty),    32'd1);
    check({p, "_rd_full"},     32'(pX_rd_full),     32'd0);
    check({p, "_rd_count"},    32'(pX_rd_count),    32'd0);
    check({p, "_rd_data"},     pX_rd_data,          32'd0);
    check({p, "_underrun"},    32'(pX_wr_underrun), 32'd0);
    check({p, "_wr_error"},    32'(pX_wr_error),    32'd0);
    check({p, "_rd_overflow"}, 32'(pX_rd_overflow), 32'd0);
    check({p, "_rd_error"},    32'(pX_rd_error),    32'd0);
  endtask

  // Monitor: owns pX_rd_en, compares every popped beat against the scoreboard.
  initial begin
    pX_rd_en = 1'b0;
    forever begin
      @(negedge clk);
      pX_rd_en = rd_allow && ($urandom_range(0, 3) != 0);
      if (pX_wr_underrun) und_cnt++;
      if (pX_rd_en && !pX_rd_empty) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: got %h expected no data", pX_rd_data);
        end else begin
          check("rd_data", pX_rd_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, d1;
    logic [2:0]  ins;
    logic [5:0]  bl;
    logic [29:0] a;
    int unsigned op, t, und0;

    reset = 1'b1;
    pX_cmd_en = 1'b0; pX_cmd_instr = '0; pX_cmd_bl = '0; pX_cmd_addr = '0;
    pX_wr_en = 1'b0; pX_wr_mask = '0; pX_wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(negedge clk);

    // Fill the whole array with known data so every later read is predictable.
    for (int unsigned b = 0; b < 16; b++) begin
      for (int unsigned w = 0; w < 64; w++) push_wr($urandom, 4'h0);
      if (b == 0) begin
        check("wr_count_64", 32'(pX_wr_count), 32'd64);
        check("wr_full_64",  32'(pX_wr_full),  32'd1);
        check("wr_error_clean", 32'(pX_wr_error), 32'd0);
      end
      push_cmd(3'b000, 6'd63, 30'(b * 256));
    end
    wait_idle();

    // write_p / read_p with first-beat latency
    push_wr(32'hDEADBEEF, 4'h0);
    push_cmd(3'b010, 6'd0, 30'h40);
    wait_idle();
    rd_allow = 1'b0;
    @(negedge clk);
    push_cmd(3'b011, 6'd0, 30'h40);
    check("lat_n_empty", 32'(pX_rd_empty), 32'd1);
    @(negedge clk);
    check("lat_n1_empty", 32'(pX_rd_empty), 32'd1);
    @(negedge clk);
    check("lat_n2_empty", 32'(pX_rd_empty), 32'd0);
    check("lat_n2_data", pX_rd_data, 32'hDEADBEEF);
    wait_idle();

    // byte-masked merge
    rd_allow = 1'b0;
    @(negedge clk);
    push_wr(32'h11223344, 4'h0);
    push_cmd(3'b000, 6'd0, 30'h0);
    push_wr(32'hAABBCCDD, 4'b0101);
    push_cmd(3'b000, 6'd0, 30'h0);
    push_cmd(3'b001, 6'd0, 30'h0);
    repeat (6) @(negedge clk);
    check("mask_merge", pX_rd_data, 32'hAA22CC44);
    wait_idle();

    // address wrap at the top of the array
    rd_allow = 1'b0;
    @(negedge clk);
    d0 = $urandom; d1 = $urandom;
    push_wr(d0, 4'h0);
    push_wr(d1, 4'h0);
    push_cmd(3'b000, 6'd1, 30'hFFC);
    push_cmd(3'b001, 6'd0, 30'h0);
    repeat (6) @(negedge clk);
    check("wrap_word0", pX_rd_data, d1);
    push_cmd(3'b001, 6'd1, 30'hFFC);
    wait_idle();

    // random mix, including undefined opcodes and upper address bits
    for (int unsigned k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      bl = 6'($urandom_range(0, 15));
      a  = 30'($urandom);
      if (op < 4) begin
        for (int unsigned i = 0; i <= 32'(bl); i++) push_wr($urandom, 4'($urandom));
        ins = op[0] ? 3'b010 : 3'b000;
      end else if (op < 9) begin
        ins = op[0] ? 3'b011 : 3'b001;
      end else begin
        ins = 3'($urandom_range(4, 7));
      end
      push_cmd(ins, bl, a);
    end
    wait_idle();

    // read FIFO fills and stalls; command FIFO full drops the fifth push
    rd_allow = 1'b0;
    @(negedge clk);
    push_cmd(3'b001, 6'd63, 30'h0);
    t = 0;
    while (!pX_rd_full && t < 200) begin @(negedge clk); t++; end
    if (!pX_rd_full) wait_expired("rd_full_wait");
    check("rd_count_64", 32'(pX_rd_count), 32'd64);
    check("rd_full_64",  32'(pX_rd_full),  32'd1);
    push_cmd(3'b001, 6'd0, 30'h80);
    repeat (3) @(negedge clk);
    check("stall_cmd_popped", 32'(pX_cmd_empty), 32'd1);
    check("stall_rd_count",   32'(pX_rd_count),  32'd64);
    for (int unsigned k = 0; k < 4; k++) push_cmd(3'b001, 6'd0, 30'(32'h200 + k * 4));
    check("cmd_full_4", 32'(pX_cmd_full), 32'd1);
    pX_cmd_en = 1'b1; pX_cmd_instr = 3'b001; pX_cmd_bl = 6'd0; pX_cmd_addr = 30'h300;
    @(negedge clk);
    pX_cmd_en = 1'b0;
    check("cmd_full_5th", 32'(pX_cmd_full), 32'd1);
    check("stall_rd_count2", 32'(pX_rd_count), 32'd64);
    check("rd_overflow_0", 32'(pX_rd_overflow), 32'd0);
    wait_idle();

    // starved write beat
    und0 = und_cnt;
    d0 = $urandom;
    push_wr(d0, 4'h0);
    push_cmd(3'b000, 6'd1, 30'h500);
    repeat (8) @(negedge clk);
    check("underrun_pulses", und_cnt - und0, 32'd1);
    check("wr_error_set", 32'(pX_wr_error), 32'd1);
    push_cmd(3'b001, 6'd1, 30'h500);
    wait_idle();
    check("wr_error_sticky", 32'(pX_wr_error), 32'd1);

    // reset in the middle of a read burst
    rd_allow = 1'b0;
    @(negedge clk);
    push_cmd(3'b001, 6'd63, 30'h800);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    reset = 1'b0;
    sb.delete();
    wdq.delete();
    @(negedge clk);
    check_reset("rst_after");
    d0 = $urandom;
    push_wr(d0, 4'h0);
    push_cmd(3'b010, 6'd0, 30'h3A4);
    push_cmd(3'b011, 6'd2, 30'h3A0);
    wait_idle();

    // push while write FIFO full is dropped and flags an error
    for (int unsigned w = 0; w < 64; w++) push_wr($urandom, 4'($urandom));
    check("wr_full_again", 32'(pX_wr_full), 32'd1);
    pX_wr_en = 1'b1; pX_wr_data = 32'h0BAD0BAD; pX_wr_mask = 4'h0;
    @(negedge clk);
    pX_wr_en = 1'b0;
    check("wr_count_drop", 32'(pX_wr_count), 32'd64);
    check("wr_error_overflow", 32'(pX_wr_error), 32'd1);
    push_cmd(3'b000, 6'd63, 30'h100);
    push_cmd(3'b001, 6'd63, 30'h100);
    wait_idle();
    check("end_wr_empty",  32'(pX_wr_empty),  32'd1);
    check("end_cmd_empty", 32'(pX_cmd_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
